mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between instruction fetch (read-only) and the load/store memory unit.

---
 rtl/my_pkg.sv | 33 +++
 rtl/mem_arb_prio.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// -----------------------------------------------------------------------------
// my_pkg
//   Shared types and constants for the memory-port arbiter.
//   - arb_state_t : arbiter FSM states
//   - arb_owner_t : which requester owns the in-flight access
//   - SZ_*        : d_size / mem_size encodings
//   - is_misaligned() : store alignment check (reads are never flagged)
// -----------------------------------------------------------------------------
package my_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam logic [1:0] SZ_READ = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Half stores need an even address, word stores a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
//   Winner selection for the shared memory port. Data wins a conflict unless
//   fetch has already lost MAX_STARVE conflicts in a row, then fetch wins.
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   f_req, d_req   : fetch / data requests
//   idle           : arbiter is in IDLE and may sample requests
//   sel_f, sel_d   : winner this cycle (at most one high, only when idle)
// -----------------------------------------------------------------------------
module mem_arb_prio #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic d_req,
    input  logic idle,
    output logic sel_f,
    output logic sel_d
);

    localparam int SW = $clog2(MAX_STARVE + 1);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved;

    assign starved = (starve_cnt_q == SW'(MAX_STARVE));

    always_comb begin
        sel_f = idle && f_req && (!d_req || starved);
        sel_d = idle && d_req && !sel_f;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        starve_cnt_d = starve_cnt_q;
        if (sel_f) begin
            starve_cnt_d = '0;
        end else if (sel_d && f_req && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and the
//   load/store unit. One access in flight at a time; data has priority with a
//   starvation guard for fetch. All memory-side and requester outputs are
//   registered.
// Parameters
//   MEM_LAT    : cycles from mem_en to valid mem_rdata (>=1)
//   MAX_STARVE : consecutive fetch losses before fetch is forced to win (>=1)
// Ports
//   clk, reset                         : clock, asynchronous active-high reset
//   f_req/f_addr -> f_gnt/f_valid/f_rdata        : fetch side
//   d_req/d_size/d_addr/d_wdata -> d_gnt/d_valid/d_err/d_rdata : data side
//   mem_en/mem_size/mem_addr/mem_wdata, mem_rdata : memory side
// Configuration
//   MEM_ARB_PERF_EN : adds perf_f_cnt, perf_d_cnt, perf_conflict_cnt outputs
//                     (32-bit wrapping grant / conflict counters).
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import my_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_f_cnt,
    output logic [31:0] perf_d_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // The grant cycle is the first ACCESS cycle, so the counter starts at MEM_LAT-1.
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic sel_f, sel_d, idle, acc_done, d_misaligned;

    logic        f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic        f_valid_q, f_valid_d, d_valid_q, d_valid_d;
    logic        d_err_q, d_err_d, err_q, err_d;
    logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    arb_owner_t  owner_q, owner_d;

    assign idle         = (state_q == ARB_IDLE);
    assign acc_done     = (state_q == ARB_ACCESS) && (cnt_q == '0);
    assign d_misaligned = is_misaligned(d_size, d_addr[1:0]);

    mem_arb_prio #(
        .MAX_STARVE (MAX_STARVE)
    ) u_prio (
        .clk   (clk),
        .reset (reset),
        .f_req (f_req),
        .d_req (d_req),
        .idle  (idle),
        .sel_f (sel_f),
        .sel_d (sel_d)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_f || sel_d) begin
                    state_d = ARB_ACCESS;
                    cnt_d   = LAT_LOAD;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values of registered outputs) ----------------
    always_comb begin
        f_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        f_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        mem_en_d    = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        err_d       = err_q;

        // sel_* only fire in IDLE and acc_done only in ACCESS, so these never overlap.
        if (sel_f) begin
            f_gnt_d    = 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = f_addr;
            mem_size_d = SZ_READ;
            owner_d    = OWN_FETCH;
            err_d      = 1'b0;
        end else if (sel_d) begin
            d_gnt_d     = 1'b1;
            // A misaligned store is granted and completed but never reaches memory.
            mem_en_d    = !d_misaligned;
            mem_addr_d  = d_addr;
            mem_size_d  = d_size;
            mem_wdata_d = d_wdata;
            owner_d     = OWN_DATA;
            err_d       = d_misaligned;
        end

        if (acc_done) begin
            if (owner_q == OWN_FETCH) begin
                f_valid_d = 1'b1;
                f_rdata_d = mem_rdata;
            end else begin
                d_valid_d = 1'b1;
                d_err_d   = err_q;
                d_rdata_d = (err_q || (mem_size_q != SZ_READ)) ? 32'h0 : mem_rdata;
            end
        end
    end

    // NOTE: every output flop is async-reset so an in-flight access is dropped with all outputs at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_size_q  <= SZ_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= OWN_FETCH;
            err_q       <= 1'b0;
        end else begin
            f_gnt_q     <= f_gnt_d;
            d_gnt_q     <= d_gnt_d;
            f_valid_q   <= f_valid_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign f_valid   = f_valid_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_f_q, perf_f_d, perf_d_q, perf_d_d, perf_c_q, perf_c_d;

    always_comb begin
        perf_f_d = perf_f_q + {31'b0, sel_f};
        perf_d_d = perf_d_q + {31'b0, sel_d};
        perf_c_d = perf_c_q + {31'b0, (idle && f_req && d_req)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_f_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_f_q <= perf_f_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_f_cnt        = perf_f_q;
    assign perf_d_cnt        = perf_d_q;
    assign perf_conflict_cnt = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. u_dut uses MEM_LAT=1, u_dut3 uses
//   MEM_LAT=3 (held in reset until the reset-during-access scenario). Both
//   share the requester/memory inputs. MEM_ARB_PERF_EN enables perf checks.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset3;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;

    logic        a_f_gnt, a_f_valid, a_d_gnt, a_d_valid, a_d_err, a_mem_en;
    logic [31:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_mem_size;

    logic        b_f_gnt, b_f_valid, b_d_gnt, b_d_valid, b_d_err, b_mem_en;
    logic [31:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_mem_size;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] a_perf_f, a_perf_d, a_perf_c, b_perf_f, b_perf_d, b_perf_c;
`endif

    mem_port_arbiter #(.MEM_LAT(1), .MAX_STARVE(4)) u_dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(a_f_gnt), .f_valid(a_f_valid), .f_rdata(a_f_rdata),
        .d_req(d_req), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_valid(a_d_valid), .d_err(a_d_err), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_size(a_mem_size), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_f_cnt(a_perf_f), .perf_d_cnt(a_perf_d), .perf_conflict_cnt(a_perf_c)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(3), .MAX_STARVE(4)) u_dut3 (
        .clk(clk), .reset(reset3),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(b_f_gnt), .f_valid(b_f_valid), .f_rdata(b_f_rdata),
        .d_req(d_req), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_err(b_d_err), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_size(b_mem_size), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_f_cnt(b_perf_f), .perf_d_cnt(b_perf_d), .perf_conflict_cnt(b_perf_c)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One data access on u_dut (MEM_LAT=1): grant next cycle, valid the one after.
    task automatic do_data(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_en, input logic exp_err,
                           input logic [31:0] exp_rdata);
        d_req = 1'b1; d_size = size; d_addr = addr; d_wdata = wdata;
        step();
        check({tag, "_gnt"},    32'(a_d_gnt),  32'd1);
        check({tag, "_mem_en"}, 32'(a_mem_en), 32'(exp_en));
        if (exp_en) begin
            check({tag, "_mem_addr"}, a_mem_addr, addr);
            check({tag, "_mem_size"}, 32'(a_mem_size), 32'(size));
            if (size != 2'b00) check({tag, "_mem_wdata"}, a_mem_wdata, wdata);
        end
        d_req = 1'b0;
        step();
        check({tag, "_valid"},  32'(a_d_valid), 32'd1);
        check({tag, "_err"},    32'(a_d_err),   32'(exp_err));
        check({tag, "_rdata"},  a_d_rdata,      exp_rdata);
        check({tag, "_en_off"}, 32'(a_mem_en),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; reset3 = 1'b1;
        f_req = 1'b0; d_req = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_size = 2'b00;
        mem_rdata = 32'hDEADBEEF;

        // Reset state
        @(negedge clk);
        step();
        check("rst_f_gnt",    32'(a_f_gnt),   32'd0);
        check("rst_mem_en",   32'(a_mem_en),  32'd0);
        check("rst_mem_addr", a_mem_addr,     32'd0);
        check("rst_d_valid",  32'(a_d_valid), 32'd0);
        reset = 1'b0;

        // 1: lone fetch
        f_req = 1'b1; f_addr = 32'h100;
        step();
        check("t1_f_gnt",    32'(a_f_gnt),    32'd1);
        check("t1_d_gnt",    32'(a_d_gnt),    32'd0);
        check("t1_mem_en",   32'(a_mem_en),   32'd1);
        check("t1_mem_addr", a_mem_addr,      32'h100);
        check("t1_mem_size", 32'(a_mem_size), 32'd0);
        f_req = 1'b0;
        step();
        check("t1_f_valid",  32'(a_f_valid),  32'd1);
        check("t1_f_rdata",  a_f_rdata,       32'hDEADBEEF);
        check("t1_gnt_off",  32'(a_f_gnt),    32'd0);

        // 2: aligned word store
        do_data("t2_word_wr", 2'b11, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h0);
        // 3: misaligned half store, then boundary cases
        do_data("t3_half_mis", 2'b10, 32'h203, 32'hAAAA5555, 1'b0, 1'b1, 32'h0);
        do_data("t3_half_ok",  2'b10, 32'h202, 32'h0000BEEF, 1'b1, 1'b0, 32'h0);
        do_data("t3_word_mis", 2'b11, 32'h206, 32'h11112222, 1'b0, 1'b1, 32'h0);
        do_data("t3_byte_odd", 2'b01, 32'h207, 32'h000000AB, 1'b1, 1'b0, 32'h0);
        mem_rdata = 32'hCAFEF00D;
        do_data("t3_read_odd", 2'b00, 32'h203, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
        check("t3_f_rdata_hold", a_f_rdata, 32'hDEADBEEF);

        // 4: sustained conflict from a clean reset -> D,D,D,D,F,D,D,D,D,F
        reset = 1'b1;
        step();
        reset = 1'b0;
        f_addr = 32'h300; d_addr = 32'h400; d_size = 2'b00;
        f_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            int   waited;
            logic exp_f;
            waited = 0;
            step();
            while (!(a_f_gnt || a_d_gnt) && waited < 8) begin
                step();
                waited++;
            end
            exp_f = (g % 5 == 4);
            check($sformatf("t4_seen_%0d", g),  32'(a_f_gnt | a_d_gnt), 32'd1);
            check($sformatf("t4_f_gnt_%0d", g), 32'(a_f_gnt), 32'(exp_f));
            check($sformatf("t4_d_gnt_%0d", g), 32'(a_d_gnt), 32'(!exp_f));
            check($sformatf("t4_addr_%0d", g),  a_mem_addr, exp_f ? 32'h300 : 32'h400);
            if (g == 9) begin
                f_req = 1'b0; d_req = 1'b0;
            end
        end
        step();
        step();
        check("t4_no_extra", 32'(a_f_gnt | a_d_gnt), 32'd0);
`ifdef MEM_ARB_PERF_EN
        check("t6_perf_d",        a_perf_d, 32'd8);
        check("t6_perf_f",        a_perf_f, 32'd2);
        check("t6_perf_conflict", a_perf_c, 32'd10);
`endif

        // 5: reset during ACCESS on the MEM_LAT=3 instance
        reset3 = 1'b0;
        mem_rdata = 32'h0BADF00D;
        f_addr = 32'h500; f_req = 1'b1;
        step();
        check("t5_gnt",      32'(b_f_gnt), 32'd1);
        check("t5_mem_addr", b_mem_addr,   32'h500);
        step();
        reset3 = 1'b1;
        #1;
        check("t5_rst_gnt",   32'(b_f_gnt),   32'd0);
        check("t5_rst_en",    32'(b_mem_en),  32'd0);
        check("t5_rst_addr",  b_mem_addr,     32'd0);
        check("t5_rst_valid", 32'(b_f_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5_hold_valid_%0d", i), 32'(b_f_valid), 32'd0);
            check($sformatf("t5_hold_gnt_%0d", i),   32'(b_f_gnt),   32'd0);
        end
        reset3 = 1'b0;
        step();
        check("t5_regrant", 32'(b_f_gnt), 32'd1);
        f_req = 1'b0;
        step();
        check("t5_lat_c2", 32'(b_f_valid), 32'd0);
        step();
        check("t5_lat_c3", 32'(b_f_valid), 32'd0);
        step();
        check("t5_valid",  32'(b_f_valid), 32'd1);
        check("t5_rdata",  b_f_rdata,      32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
